qdr_status_mon: RTL and testbench
=================================

# qdr_status_mon

Status monitor sitting directly downstream of the QDRII example-design clock/reset glue. It runs on the MIG user clock, consumes the calibration-done and compare-error flags from the traffic generator, and turns them into registered board-level status. Outputs are a calibration-timeout flag, a sticky error flag with a saturating error counter, LED drives, and a heartbeat. Its job is to turn momentary MIG flags into persistent, human-visible board status.

## Interface
- CAL_TIMEOUT, 2**20: sys_clk cycles allowed from reset or recalibration start for cal_done to rise.
- HB_DIV_LOG2, 24: heartbeat period is 2**HB_DIV_LOG2 cycles; led_hb is the divider MSB.
- ERR_CNT_W, 16: width of err_count.

Ports:
- sys_clk  in  1  MIG user clock; the only clock.
- sys_rst  in  1  synchronous, active-high reset.
- cal_done  in  1  MIG calibration complete, level, sys_clk domain.
- compare_error  in  1  traffic-generator data miscompare, 1-cycle or level.
- err_clr  in  1  single-cycle request to clear the sticky error and the counter.
- state  out  2  current FSM state: 00 WAIT_CAL, 01 RUN, 10 ERR, 11 TIMEOUT.
- cal_timeout  out  1  high while in TIMEOUT.
- err_sticky  out  1  set on any miscompare seen in RUN or ERR.
- err_count  out  ERR_CNT_W  miscompare cycles counted, saturating.
- led_cal  out  1  high in RUN or ERR.
- led_err  out  1  err_sticky OR cal_timeout.
- led_hb  out  1  free-running heartbeat.

## Operation
- Reset values: state=WAIT_CAL, cal timer=0, heartbeat divider=0, and every output is 0.
- WAIT_CAL:
  - Timer increments each cycle.
  - cal_done=1 goes to RUN and clears the timer.
  - Otherwise, timer==CAL_TIMEOUT-1 goes to TIMEOUT.
  - If cal_done and the timeout fire in the same cycle, cal_done wins.
- RUN:
  - compare_error=1 goes to ERR, sets err_sticky and increments err_count.
  - cal_done=0 (recalibration) goes to WAIT_CAL and restarts the timer from 0. err_sticky and err_count are preserved.
  - If cal_done=0 and compare_error arrive together, WAIT_CAL wins and the error is ignored.
- ERR:
  - Every cycle with compare_error=1 increments err_count.
  - err_clr=1 clears err_sticky and err_count. The next state is RUN if cal_done=1, else WAIT_CAL.
  - If err_clr and compare_error arrive together, the clear is applied first and then the error: err_count=1, err_sticky=1, state stays ERR.
  - cal_done=0 without err_clr goes to WAIT_CAL; the sticky flag is preserved.
- TIMEOUT: terminal until sys_rst. cal_done, compare_error and err_clr are ignored.
- err_clr outside ERR clears err_sticky and err_count only; the state is unaffected.
- compare_error is ignored in WAIT_CAL and TIMEOUT.
- err_count saturates at 2**ERR_CNT_W-1 and never wraps.
- The heartbeat divider free-runs in every state, including TIMEOUT, and wraps naturally.

## Timing
- Every output is a flop; there are no combinational input-to-output paths.
- Latency is 1 cycle: an input sampled at edge N is reflected on state and outputs after edge N.
- TIMEOUT asserts exactly CAL_TIMEOUT cycles after sys_rst deasserts, provided cal_done stays 0.
- led_hb toggles every 2**(HB_DIV_LOG2-1) cycles.
- sys_rst asserted mid-operation returns all state to reset values at the next edge, regardless of current state.

## Configuration
- QDR_STATUS_ERRCNT_EN defined: the err_count register and saturating increment are built as described.
- QDR_STATUS_ERRCNT_EN undefined:
  - err_count is tied to 0 and no counter flops are built.
  - err_sticky, the FSM and the LEDs behave identically.

## Test plan
Simulation parameters: CAL_TIMEOUT=16, HB_DIV_LOG2=4, ERR_CNT_W=4, QDR_STATUS_ERRCNT_EN defined.

- Reset release, cal_done held 0 -> state=11, cal_timeout=1, led_err=1 exactly 16 cycles after release; a later cal_done=1 leaves state=11.
- cal_done rises on cycle 5 -> state=01, led_cal=1 one cycle later; the timeout never fires.
- RUN, three single-cycle compare_error pulses -> state=10, err_sticky=1, err_count=3; err_clr with cal_done=1 -> state=01, err_count=0, err_sticky=0.
- ERR, compare_error held 20 cycles -> err_count saturates at 15; err_clr and compare_error in the same cycle -> err_count=1, state=10.
- RUN with err_count=2, cal_done drops -> state=00, err_count=2 held; cal_done re-rises within 16 cycles -> state=01.
- Free-run -> led_hb toggles every 8 cycles; sys_rst mid-ERR -> all outputs 0 and state=00 after the next edge.

Source files
------------

// File: rtl/qdr_status_mon.sv
// Board-level status monitor for the QDRII example design: calibration timeout, sticky miscompare flag, LEDs, heartbeat.
// Optional macro QDR_STATUS_ERRCNT_EN builds the saturating err_count register; otherwise err_count is tied to 0.
module qdr_status_mon #(
    parameter int CAL_TIMEOUT = 2**20,
    parameter int HB_DIV_LOG2 = 24,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 cal_done,
    input  logic                 compare_error,
    input  logic                 err_clr,
    output logic [1:0]           state,
    output logic                 cal_timeout,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 led_cal,
    output logic                 led_err,
    output logic                 led_hb
);

    localparam int TMR_W = (CAL_TIMEOUT > 1) ? $clog2(CAL_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        WAIT_CAL = 2'b00,
        RUN      = 2'b01,
        ERR      = 2'b10,
        TIMEOUT  = 2'b11
    } state_t;

    state_t                 state_q, state_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [HB_DIV_LOG2-1:0] hb_q;
    logic                   err_sticky_q, err_sticky_d;
    logic                   cal_timeout_q, led_cal_q, led_err_q;
    logic                   err_hit;
    logic                   clr_hit;

    // Timer only runs in WAIT_CAL; every other state holds it at zero so re-entry starts fresh.
    always_comb begin
        state_d = state_q;
        timer_d = '0;
        err_hit = 1'b0;
        clr_hit = 1'b0;
        case (state_q)
            WAIT_CAL: begin
                clr_hit = err_clr;
                if (cal_done) begin
                    state_d = RUN;
                end else if (timer_q == TMR_W'(CAL_TIMEOUT - 1)) begin
                    state_d = TIMEOUT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            RUN: begin
                clr_hit = err_clr;
                if (!cal_done) begin
                    state_d = WAIT_CAL;
                end else if (compare_error) begin
                    state_d = ERR;
                    err_hit = 1'b1;
                end
            end
            ERR: begin
                clr_hit = err_clr;
                err_hit = compare_error;
                if (err_clr) begin
                    // Clear is applied before a coincident error, which keeps us in ERR.
                    if (compare_error)  state_d = ERR;
                    else if (cal_done)  state_d = RUN;
                    else                state_d = WAIT_CAL;
                end else if (!cal_done) begin
                    state_d = WAIT_CAL;
                end
            end
            TIMEOUT: begin
                state_d = TIMEOUT;
            end
            default: begin
                state_d = WAIT_CAL;
            end
        endcase
        err_sticky_d = (err_sticky_q & ~clr_hit) | err_hit;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q       <= WAIT_CAL;
            timer_q       <= '0;
            hb_q          <= '0;
            err_sticky_q  <= 1'b0;
            cal_timeout_q <= 1'b0;
            led_cal_q     <= 1'b0;
            led_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            hb_q          <= hb_q + HB_DIV_LOG2'(1);
            err_sticky_q  <= err_sticky_d;
            cal_timeout_q <= (state_d == TIMEOUT);
            led_cal_q     <= (state_d == RUN) || (state_d == ERR);
            led_err_q     <= err_sticky_d || (state_d == TIMEOUT);
        end
    end

`ifdef QDR_STATUS_ERRCNT_EN
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = clr_hit ? '0 : err_cnt_q;
        if (err_hit && (err_cnt_d != CNT_MAX)) begin
            err_cnt_d = err_cnt_d + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) err_cnt_q <= '0;
        else         err_cnt_q <= err_cnt_d;
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

    assign state       = state_q;
    assign cal_timeout = cal_timeout_q;
    assign err_sticky  = err_sticky_q;
    assign led_cal     = led_cal_q;
    assign led_err     = led_err_q;
    assign led_hb      = hb_q[HB_DIV_LOG2-1];

endmodule

// File: tb/tb_qdr_status_mon.sv
// Self-checking bench for qdr_status_mon: vector table, directed corner sequences, randomized run against a cycle model.
module tb_qdr_status_mon;
    localparam int CT = 16;
    localparam int HB = 4;
    localparam int W  = 4;
    localparam int CNT_MAX = (1 << W) - 1;
    localparam int HB_PERIOD = 1 << HB;
`ifdef QDR_STATUS_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cd = 1'b0;
    logic         ce = 1'b0;
    logic         clr = 1'b0;
    logic [1:0]   state;
    logic         cal_timeout, err_sticky, led_cal, led_err, led_hb;
    logic [W-1:0] err_count;

    qdr_status_mon #(.CAL_TIMEOUT(CT), .HB_DIV_LOG2(HB), .ERR_CNT_W(W)) dut (
        .sys_clk(clk), .sys_rst(rst), .cal_done(cd), .compare_error(ce), .err_clr(clr),
        .state(state), .cal_timeout(cal_timeout), .err_sticky(err_sticky), .err_count(err_count),
        .led_cal(led_cal), .led_err(led_err), .led_hb(led_hb)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: state code 0 WAIT_CAL, 1 RUN, 2 ERR, 3 TIMEOUT; wait_cycles counts cycles spent waiting for calibration.
    int m_state = 0;
    int wait_cycles = 0;
    int m_cnt = 0;
    bit m_sticky = 0;
    int m_cycle = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        bit r; bit c; bit e; bit k;
        int st; bit sk; int cnt;
    } vec_t;
    vec_t vecs[15];

    function automatic vec_t mk(bit r, bit c, bit e, bit k, int st, bit sk, int cnt);
        vec_t v;
        v.r = r; v.c = c; v.e = e; v.k = k; v.st = st; v.sk = sk; v.cnt = CNT_EN ? cnt : 0;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit c, input bit e, input bit k);
        bit counted;
        bit cleared;
        counted = 0;
        cleared = 0;
        if (r) begin
            m_state = 0; wait_cycles = 0; m_cnt = 0; m_sticky = 0; m_cycle = 0;
        end else begin
            m_cycle++;
            if (m_state != 3) cleared = k;
            if (m_state == 0) begin
                wait_cycles++;
                if (c) begin m_state = 1; wait_cycles = 0; end
                else if (wait_cycles >= CT) m_state = 3;
            end else if (m_state == 1) begin
                if (!c) m_state = 0;
                else if (e) begin m_state = 2; counted = 1; end
            end else if (m_state == 2) begin
                counted = e;
                if (k) m_state = e ? 2 : (c ? 1 : 0);
                else if (!c) m_state = 0;
            end
            if (m_state == 0 && wait_cycles == 0 && !c) wait_cycles = 0;
            if (cleared) begin m_sticky = 0; m_cnt = 0; end
            if (counted) begin
                m_sticky = 1;
                if (m_cnt < CNT_MAX) m_cnt++;
            end
        end
        if (m_state != 0) wait_cycles = 0;
        exp_q.push_back(CNT_EN ? W'(m_cnt) : '0);
    endtask

    task automatic check_model();
        logic [W-1:0] exp_cnt;
        exp_cnt = exp_q.pop_front();
        chk("state", int'(state), m_state);
        chk("cal_timeout", int'(cal_timeout), int'(m_state == 3));
        chk("err_sticky", int'(err_sticky), int'(m_sticky));
        chk("err_count", int'(err_count), int'(exp_cnt));
        chk("led_cal", int'(led_cal), int'(m_state == 1 || m_state == 2));
        chk("led_err", int'(led_err), int'(m_sticky || m_state == 3));
        chk("led_hb", int'(led_hb), int'((m_cycle % HB_PERIOD) >= HB_PERIOD / 2));
    endtask

    task automatic step(input bit r, input bit c, input bit e, input bit k);
        rst = r; cd = c; ce = e; clr = k;
        @(posedge clk);
        model_update(r, c, e, k);
        #1;
        check_model();
    endtask

    task automatic go_err();
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
    endtask

    initial begin
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 0, 0, 1, 0, 0);
        vecs[2]  = mk(0, 1, 1, 0, 2, 1, 1);
        vecs[3]  = mk(0, 1, 0, 0, 2, 1, 1);
        vecs[4]  = mk(0, 1, 1, 0, 2, 1, 2);
        vecs[5]  = mk(0, 1, 1, 0, 2, 1, 3);
        vecs[6]  = mk(0, 1, 0, 1, 1, 0, 0);
        vecs[7]  = mk(0, 1, 1, 0, 2, 1, 1);
        vecs[8]  = mk(0, 1, 1, 1, 2, 1, 1);
        vecs[9]  = mk(0, 0, 0, 0, 0, 1, 1);
        vecs[10] = mk(0, 0, 1, 0, 0, 1, 1);
        vecs[11] = mk(0, 1, 0, 0, 1, 1, 1);
        vecs[12] = mk(0, 0, 1, 0, 0, 1, 1);
        vecs[13] = mk(0, 0, 0, 1, 0, 0, 0);
        vecs[14] = mk(0, 1, 0, 0, 1, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", int'(state), 0);
        chk("reset_leds", int'({cal_timeout, err_sticky, led_cal, led_err, led_hb}), 0);
        chk("reset_count", int'(err_count), 0);

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].r, vecs[i].c, vecs[i].e, vecs[i].k);
            chk($sformatf("vec%0d_state", i), int'(state), vecs[i].st);
            chk($sformatf("vec%0d_sticky", i), int'(err_sticky), int'(vecs[i].sk));
            chk($sformatf("vec%0d_count", i), int'(err_count), vecs[i].cnt);
        end

        // Timeout fires exactly CT cycles after reset release and is terminal.
        step(1, 0, 0, 0);
        for (int i = 1; i < CT; i++) step(0, 0, 0, 0);
        chk("pre_timeout_state", int'(state), 0);
        step(0, 0, 0, 0);
        chk("timeout_state", int'(state), 3);
        chk("timeout_flag", int'(cal_timeout), 1);
        chk("timeout_led_err", int'(led_err), 1);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1);
        chk("timeout_terminal", int'(state), 3);

        // cal_done on cycle 5 reaches RUN, timeout never fires.
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("cal5_state", int'(state), 1);
        chk("cal5_led_cal", int'(led_cal), 1);
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0);
        chk("cal5_no_timeout", int'(cal_timeout), 0);

        // Saturation then coincident clear+error.
        go_err();
        for (int i = 0; i < 20; i++) step(0, 1, 1, 0);
        chk("sat_count", int'(err_count), CNT_EN ? CNT_MAX : 0);
        step(0, 1, 1, 1);
        chk("clr_err_count", int'(err_count), CNT_EN ? 1 : 0);
        chk("clr_err_state", int'(state), 2);

        // Recalibration from RUN keeps the count.
        go_err();
        step(0, 1, 1, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("recal_run", int'(state), 1);
        step(0, 0, 0, 0);
        chk("recal_wait", int'(state), 0);
        chk("recal_count", int'(err_count), CNT_EN ? 2 : 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("recal_back", int'(state), 1);

        // Heartbeat toggles every HB_PERIOD/2 cycles.
        step(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
        chk("hb_low", int'(led_hb), 0);
        step(0, 1, 0, 0);
        chk("hb_rise", int'(led_hb), 1);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
        chk("hb_fall", int'(led_hb), 0);

        // Reset in ERR.
        go_err();
        step(1, 1, 1, 0);
        chk("rst_err_state", int'(state), 0);
        chk("rst_err_outs", int'({cal_timeout, err_sticky, led_cal, led_err, led_hb}), 0);
        chk("rst_err_count", int'(err_count), 0);

        // Randomized run.
        step(1, 0, 0, 0);
        begin
            bit cur_cd;
            cur_cd = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 11) == 0) cur_cd = ~cur_cd;
                step($urandom_range(0, 299) == 0, cur_cd,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
